mac_loa_param: RTL and testbench

Parametrised, multi-cycle approximate multiply-accumulate unit built on a Lower-part-OR Adder (LOA). It extends the fixed 16-bit LOA MAC in three ways:
- configurable operand width, accumulator width and approximate-part size;
- a persistent accumulator, so dot products span many `start` operations;
- a `busy` status output and a sticky overflow flag.

It sits in the low-power DSP datapath as the shared MAC engine for the FIR and correlator blocks.

---
 rtl/mac_loa_param_if.sv | 19 +
 rtl/mac_loa_param.sv | 134 +++++++++++++
 tb/tb_mac_loa_param.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mac_loa_param_if.sv
// Request/status bundle for the LOA multiply-accumulate engine.
// Handshake: a request is accepted on a rising edge where start=1 and busy=0;
// clr/a/b are captured on that edge only, and done pulses once when acc is updated.
interface mac_loa_param_if #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
);
  logic             start;
  logic             clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [ACC_W-1:0] acc;
  logic             done;
  logic             busy;
  logic             ovf;

  modport master (output start, clr, a, b, input acc, done, busy, ovf);
  modport slave  (input start, clr, a, b, output acc, done, busy, ovf);
endinterface

// File: rtl/mac_loa_param.sv
// Sequential shift-add approximate MAC with a persistent accumulator, built on Lower-part-OR adders.
// Build option MAC_SAT_EN: accumulator saturates to all-ones on overflow instead of wrapping.
module mac_loa_param #(
  parameter int WIDTH    = 16,
  parameter int ACC_W    = 40,
  parameter int LOA_BITS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_loa_param_if.slave mac_s,
  output logic [1:0]     state_o
);
  localparam int PW    = 2 * WIDTH;
  localparam int AW1   = ACC_W + 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int KIDX  = (LOA_BITS > 0) ? LOA_BITS - 1 : 0;
  localparam logic [PW-1:0]    LO_MASK_P = {PW{1'b1}} >> (PW - LOA_BITS);
  localparam logic [ACC_W-1:0] LO_MASK_A = {ACC_W{1'b1}} >> (ACC_W - LOA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

  // Low part is a plain OR; the upper part adds exactly with the carry taken from bit k-1 of both inputs.
  function automatic logic [PW-1:0] loa_p(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic          cin;
    logic [PW-1:0] hi;
    cin = (LOA_BITS > 0) ? (x[KIDX] & y[KIDX]) : 1'b0;
    hi  = (x & ~LO_MASK_P) + (y & ~LO_MASK_P) + (PW'(cin) << LOA_BITS);
    return hi | ((x | y) & LO_MASK_P);
  endfunction

  function automatic logic [ACC_W:0] loa_a(input logic [ACC_W-1:0] x, input logic [ACC_W-1:0] y);
    logic         cin;
    logic [ACC_W:0] hi;
    cin = (LOA_BITS > 0) ? (x[KIDX] & y[KIDX]) : 1'b0;
    hi  = {1'b0, x & ~LO_MASK_A} + {1'b0, y & ~LO_MASK_A} + (AW1'(cin) << LOA_BITS);
    return {hi[ACC_W], hi[ACC_W-1:0] | ((x | y) & LO_MASK_A)};
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    p_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             clr_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             done_q;
  logic             busy_q;

  logic [PW-1:0]    mul_sum;
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W:0]   acc_sum;

  assign p_ext   = ACC_W'(p_q);
  assign mul_sum = loa_p(p_q, mcand_q);
  assign acc_sum = loa_a(acc_q, p_ext);

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_q) begin
      acc_d = p_ext;
    end else begin
      acc_d = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef MAC_SAT_EN
        acc_d = '1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      clr_q    <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mac_s.start) begin
            state_q  <= ST_MUL;
            cnt_q    <= '0;
            p_q      <= '0;
            mcand_q  <= PW'(mac_s.a);
            mplier_q <= mac_s.b;
            clr_q    <= mac_s.clr;
            busy_q   <= 1'b1;
            if (mac_s.clr) ovf_q <= 1'b0;
          end
        end
        ST_MUL: begin
          // Operands are shifted so the current multiplier bit is always bit 0.
          if (mplier_q[0]) p_q <= mul_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_ACC;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_ACC: begin
          acc_q   <= acc_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mac_s.acc  = acc_q;
  assign mac_s.ovf  = ovf_q;
  assign mac_s.done = done_q;
  assign mac_s.busy = busy_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_mac_loa_param.sv
// Directed bench for mac_loa_param: four parameterisations side by side, sharing clock and reset.
module tb_mac_loa_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_loa_param_if #(.WIDTH(16), .ACC_W(40)) if_e ();
  mac_loa_param_if #(.WIDTH(16), .ACC_W(40)) if_x ();
  mac_loa_param_if #(.WIDTH(4),  .ACC_W(8))  if_o ();
  mac_loa_param_if #(.WIDTH(4),  .ACC_W(8))  if_z ();
  logic [1:0] st_e, st_x, st_o, st_z;

  mac_loa_param #(.WIDTH(16), .ACC_W(40), .LOA_BITS(0)) u_exact (
    .clk(clk), .rst_n(rst_n), .mac_s(if_e.slave), .state_o(st_e));
  mac_loa_param #(.WIDTH(16), .ACC_W(40), .LOA_BITS(4)) u_approx (
    .clk(clk), .rst_n(rst_n), .mac_s(if_x.slave), .state_o(st_x));
  mac_loa_param #(.WIDTH(4), .ACC_W(8), .LOA_BITS(0)) u_ovf (
    .clk(clk), .rst_n(rst_n), .mac_s(if_o.slave), .state_o(st_o));
  mac_loa_param #(.WIDTH(4), .ACC_W(8), .LOA_BITS(2)) u_exh (
    .clk(clk), .rst_n(rst_n), .mac_s(if_z.slave), .state_o(st_z));

  logic [63:0] acc_v [4];
  logic        done_v [4];
  logic        busy_v [4];
  logic        ovf_v [4];
  assign acc_v[0] = 64'(if_e.acc);  assign done_v[0] = if_e.done;
  assign acc_v[1] = 64'(if_x.acc);  assign done_v[1] = if_x.done;
  assign acc_v[2] = 64'(if_o.acc);  assign done_v[2] = if_o.done;
  assign acc_v[3] = 64'(if_z.acc);  assign done_v[3] = if_z.done;
  assign busy_v[0] = if_e.busy;     assign ovf_v[0] = if_e.ovf;
  assign busy_v[1] = if_x.busy;     assign ovf_v[1] = if_x.ovf;
  assign busy_v[2] = if_o.busy;     assign ovf_v[2] = if_o.ovf;
  assign busy_v[3] = if_z.busy;     assign ovf_v[3] = if_z.ovf;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic s, input logic c,
                       input logic [15:0] av, input logic [15:0] bv);
    case (d)
      0: begin if_e.start = s; if_e.clr = c; if_e.a = av; if_e.b = bv; end
      1: begin if_x.start = s; if_x.clr = c; if_x.a = av; if_x.b = bv; end
      2: begin if_o.start = s; if_o.clr = c; if_o.a = av[3:0]; if_o.b = bv[3:0]; end
      default: begin if_z.start = s; if_z.clr = c; if_z.a = av[3:0]; if_z.b = bv[3:0]; end
    endcase
  endtask

  task automatic stop(input int d);
    case (d)
      0: if_e.start = 1'b0;
      1: if_x.start = 1'b0;
      2: if_o.start = 1'b0;
      default: if_z.start = 1'b0;
    endcase
  endtask

  // Expects start already driven; lat counts edges after the accept edge up to done.
  task automatic wait_done(input int d, output int lat);
    lat = 0;
    @(posedge clk); #1;
    @(negedge clk); stop(d);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done_v[d]) break;
    end
  endtask

  task automatic mac(input int d, input logic [15:0] av, input logic [15:0] bv,
                     input logic c, output int lat);
    @(negedge clk); drive(d, 1'b1, c, av, bv);
    wait_done(d, lat);
  endtask

  function automatic logic [7:0] ref_loa8(input logic [7:0] x, input logic [7:0] y);
    logic       c;
    logic [5:0] up;
    c  = x[1] & y[1];
    up = x[7:2] + y[7:2] + {5'b0, c};
    return {up, x[1:0] | y[1:0]};
  endfunction

  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = ref_loa8(p, 8'(a) << i);
    return p;
  endfunction

  initial begin
    int lat;
    int done_cnt;
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) drive(d, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_acc", acc_v[0], 64'd0);
    check("rst_done", 64'(done_v[0]), 64'd0);
    check("rst_busy", 64'(busy_v[0]), 64'd0);
    check("rst_ovf", 64'(ovf_v[0]), 64'd0);
    check("rst_state", 64'(st_e), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Exact accumulation chain
    exp_q.push_back(64'd12); exp_q.push_back(64'd42); exp_q.push_back(64'd98);
    mac(0, 16'd3, 16'd4, 1'b1, lat);
    check("ex1_acc", acc_v[0], exp_q.pop_front()); check("ex1_lat", 64'(lat), 64'd17);
    mac(0, 16'd5, 16'd6, 1'b0, lat);
    check("ex2_acc", acc_v[0], exp_q.pop_front()); check("ex2_lat", 64'(lat), 64'd17);
    mac(0, 16'd7, 16'd8, 1'b0, lat);
    check("ex3_acc", acc_v[0], exp_q.pop_front()); check("ex3_lat", 64'(lat), 64'd17);
    check("ex3_ovf", 64'(ovf_v[0]), 64'd0);

    // Approximate products, LOA_BITS=4
    mac(1, 16'd3, 16'd3, 1'b1, lat);
    check("apx_3x3", acc_v[1], 64'd7);
    mac(1, 16'd15, 16'd15, 1'b1, lat);
    check("apx_15x15", acc_v[1], 64'd239); check("apx_lat", 64'(lat), 64'd17);
    mac(1, 16'd0, 16'd65535, 1'b1, lat);
    check("apx_0xffff", acc_v[1], 64'd0);

    // Overflow on an 8-bit accumulator
    mac(2, 16'd15, 16'd15, 1'b1, lat);
    check("ovf1_acc", acc_v[2], 64'd225); check("ovf1_flag", 64'(ovf_v[2]), 64'd0);
    check("ovf1_lat", 64'(lat), 64'd5);
    mac(2, 16'd15, 16'd15, 1'b0, lat);
`ifdef MAC_SAT_EN
    check("ovf2_acc", acc_v[2], 64'd255);
`else
    check("ovf2_acc", acc_v[2], 64'd194);
`endif
    check("ovf2_flag", 64'(ovf_v[2]), 64'd1);
    mac(2, 16'd1, 16'd1, 1'b0, lat);
`ifdef MAC_SAT_EN
    check("ovf3_acc", acc_v[2], 64'd255);
`else
    check("ovf3_acc", acc_v[2], 64'd195);
`endif
    check("ovf3_sticky", 64'(ovf_v[2]), 64'd1);
    mac(2, 16'd1, 16'd1, 1'b1, lat);
    check("ovf4_acc", acc_v[2], 64'd1); check("ovf4_flag", 64'(ovf_v[2]), 64'd0);

    // Busy: ignored start at E5, start held through the done cycle
    @(negedge clk); drive(0, 1'b1, 1'b1, 16'd10, 16'd10);
    @(posedge clk); #1;
    check("busy_e0", 64'(busy_v[0]), 64'd1);
    done_cnt = 0;
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      if (e == 1 || e == 6) stop(0);
      if (e == 5) drive(0, 1'b1, 1'b0, 16'd9, 16'd9);
      if (e == 17) drive(0, 1'b1, 1'b0, 16'd2, 16'd2);
      @(posedge clk); #1;
      if (done_v[0]) done_cnt++;
      check($sformatf("busy_e%0d", e), 64'(busy_v[0]), (e <= 16 || e == 18) ? 64'd1 : 64'd0);
      check($sformatf("done_e%0d", e), 64'(done_v[0]), (e == 17) ? 64'd1 : 64'd0);
      if (e == 17) check("busy_acc", acc_v[0], 64'd100);
      if (e == 18) check("b2b_state", 64'(st_e), 64'd1);
    end
    check("done_once", 64'(done_cnt), 64'd1);
    @(negedge clk); stop(0);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      @(posedge clk); #1;
      lat++;
      if (done_v[0]) break;
    end
    check("b2b_lat", 64'(lat), 64'd17);
    check("b2b_acc", acc_v[0], 64'd104);

    // Reset in the middle of a multiply
    @(negedge clk); drive(0, 1'b1, 1'b0, 16'd100, 16'd100);
    @(posedge clk); #1;
    @(negedge clk); stop(0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_acc", acc_v[0], 64'd0);
    check("mid_rst_busy", 64'(busy_v[0]), 64'd0);
    check("mid_rst_state", 64'(st_e), 64'd0);
    done_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_v[0]) done_cnt++;
    end
    check("mid_rst_nodone", 64'(done_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1; drive(0, 1'b1, 1'b0, 16'd2, 16'd3);
    wait_done(0, lat);
    check("post_rst_lat", 64'(lat), 64'd17);
    check("post_rst_acc", acc_v[0], 64'd6);

    // Exhaustive 4x4 against the reference LOA model
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mac(3, 16'(a), 16'(b), 1'b1, lat);
        check($sformatf("exh_a%0d_b%0d", a, b), acc_v[3], 64'(ref_mul(4'(a), 4'(b))));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
